// File: rtl/network_interface_tx_if.sv
// Flit types shared by the NI transmitter and its environment, and the NI <-> core/router bundle.
// master: the NI transmit side; slave: the local core and the router input port.
package network_interface_tx_pkg;
    localparam int VC_NUM            = 4;
    localparam int VC_SIZE           = $clog2(VC_NUM);
    localparam int DEST_ADDR_SIZE_X  = 4;
    localparam int DEST_ADDR_SIZE_Y  = 4;
    localparam int HEAD_PAYLOAD_SIZE = 8;
    localparam int FLIT_DATA_SIZE    = DEST_ADDR_SIZE_X + DEST_ADDR_SIZE_Y + HEAD_PAYLOAD_SIZE;

    typedef enum logic [1:0] {HEAD = 2'd0, BODY = 2'd1, TAIL = 2'd2, HEADTAIL = 2'd3} flit_label_t;

    typedef struct packed {
        logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
        logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
        logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
    } head_data_t;

    typedef union packed {
        head_data_t                head_data;
        logic [FLIT_DATA_SIZE-1:0] bt_pl;
    } flit_data_t;

    typedef struct packed {
        flit_label_t        flit_label;
        logic [VC_SIZE-1:0] vc_id;
        flit_data_t         data;
    } flit_t;
endpackage

interface network_interface_tx_if
    import network_interface_tx_pkg::*;
#(
    parameter int MAX_PKT_SIZE = 16
);
    localparam int SIZE_W = $clog2(MAX_PKT_SIZE + 1);

    logic                         pkt_valid_i;
    logic                         pkt_ready_o;
    logic [DEST_ADDR_SIZE_X-1:0]  x_dest_i;
    logic [DEST_ADDR_SIZE_Y-1:0]  y_dest_i;
    logic [HEAD_PAYLOAD_SIZE-1:0] head_pl_i;
    logic [SIZE_W-1:0]            pkt_size_i;
    logic                         body_valid_i;
    logic                         body_ready_o;
    logic [FLIT_DATA_SIZE-1:0]    body_data_i;
    flit_t                        data_o;
    logic                         valid_flit_o;
    logic [VC_NUM-1:0]            on_off_i;
    logic [VC_NUM-1:0]            vc_allocatable_i;

    modport master (
        input  pkt_valid_i, x_dest_i, y_dest_i, head_pl_i, pkt_size_i,
        input  body_valid_i, body_data_i, on_off_i, vc_allocatable_i,
        output pkt_ready_o, body_ready_o, data_o, valid_flit_o
    );

    modport slave (
        output pkt_valid_i, x_dest_i, y_dest_i, head_pl_i, pkt_size_i,
        output body_valid_i, body_data_i, on_off_i, vc_allocatable_i,
        input  pkt_ready_o, body_ready_o, data_o, valid_flit_o
    );
endinterface

// File: rtl/network_interface_tx.sv
// NoC network-interface transmitter: turns a core header + body stream into VC-tagged flits.
// Define NI_TX_VC_ROUND_ROBIN_EN for round-robin VC choice; default is fixed lowest-index priority.
// state | meaning
// IDLE  | waiting for a header while some VC is idle and on
// SEND  | emitting flits of the latched packet on cur_vc
module network_interface_tx
    import network_interface_tx_pkg::*;
#(
    parameter int MAX_PKT_SIZE = 16
) (
    input logic                   clk,
    input logic                   rst,
    network_interface_tx_if.master ni
);
    localparam int SIZE_W = $clog2(MAX_PKT_SIZE + 1);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t                       state;
    logic [VC_SIZE-1:0]           cur_vc;
    logic [SIZE_W-1:0]            cnt;
    logic [SIZE_W-1:0]            size_q;
    logic [DEST_ADDR_SIZE_X-1:0]  x_q;
    logic [DEST_ADDR_SIZE_Y-1:0]  y_q;
    logic [HEAD_PAYLOAD_SIZE-1:0] hp_q;
    flit_t                        data_q;
    logic                         valid_q;

    logic [VC_NUM-1:0]  eligible;
    logic [VC_SIZE-1:0] sel_vc;
    logic               found;
    logic [SIZE_W-1:0]  size_in;
    logic               emit;
    logic               last;
    flit_t              flit_next;

`ifdef NI_TX_VC_ROUND_ROBIN_EN
    logic [VC_SIZE-1:0] rr_ptr;
    logic [VC_SIZE-1:0] idx;

    // Search starts one past the last VC used; VC_NUM is a power of two so the index wraps.
    always_comb begin
        sel_vc = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < VC_NUM; i++) begin
            idx = rr_ptr + VC_SIZE'(i + 1);
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                sel_vc = idx;
            end
        end
    end
`else
    always_comb begin
        sel_vc = '0;
        found  = 1'b0;
        for (int i = 0; i < VC_NUM; i++) begin
            if (!found && eligible[i]) begin
                found  = 1'b1;
                sel_vc = VC_SIZE'(i);
            end
        end
    end
`endif

    assign eligible = ni.vc_allocatable_i & ni.on_off_i;

    always_comb begin
        if (ni.pkt_size_i == '0)
            size_in = SIZE_W'(1);
        else if (ni.pkt_size_i > SIZE_W'(MAX_PKT_SIZE))
            size_in = SIZE_W'(MAX_PKT_SIZE);
        else
            size_in = ni.pkt_size_i;
    end

    assign emit = (state == SEND) && ni.on_off_i[cur_vc] && ((cnt == '0) || ni.body_valid_i);
    assign last = (cnt == size_q - SIZE_W'(1));

    always_comb begin
        flit_next       = '0;
        flit_next.vc_id = cur_vc;
        if (size_q == SIZE_W'(1))
            flit_next.flit_label = HEADTAIL;
        else if (cnt == '0)
            flit_next.flit_label = HEAD;
        else if (last)
            flit_next.flit_label = TAIL;
        else
            flit_next.flit_label = BODY;
        if (cnt == '0) begin
            flit_next.data.head_data.x_dest  = x_q;
            flit_next.data.head_data.y_dest  = y_q;
            flit_next.data.head_data.head_pl = hp_q;
        end else begin
            flit_next.data.bt_pl = ni.body_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cur_vc  <= '0;
            cnt     <= '0;
            size_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            hp_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
`ifdef NI_TX_VC_ROUND_ROBIN_EN
            rr_ptr  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (ni.pkt_valid_i && found) begin
                        x_q    <= ni.x_dest_i;
                        y_q    <= ni.y_dest_i;
                        hp_q   <= ni.head_pl_i;
                        size_q <= size_in;
                        cur_vc <= sel_vc;
                        cnt    <= '0;
                        state  <= SEND;
`ifdef NI_TX_VC_ROUND_ROBIN_EN
                        rr_ptr <= sel_vc;
`endif
                    end
                end
                SEND: begin
                    if (emit) begin
                        valid_q <= 1'b1;
                        data_q  <= flit_next;
                        cnt     <= cnt + SIZE_W'(1);
                        if (last)
                            state <= IDLE;
                    end else begin
                        valid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ni.pkt_ready_o  = (state == IDLE) && found;
    assign ni.body_ready_o = (state == SEND) && (cnt != '0) && ni.on_off_i[cur_vc];
    assign ni.data_o       = data_q;
    assign ni.valid_flit_o = valid_q;
endmodule

// File: tb/tb_network_interface_tx.sv
// Directed bench for network_interface_tx: hand-computed flit sequences checked with immediate assertions.
module tb_network_interface_tx;
    import network_interface_tx_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    network_interface_tx_if #(.MAX_PKT_SIZE(16)) bus ();
    network_interface_tx #(.MAX_PKT_SIZE(16)) dut (.clk(clk), .rst(rst), .ni(bus));

    int n_cmp = 0;
    int n_err = 0;
    logic [1:0] rr_exp [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input flit_label_t lbl, input logic [1:0] vc, input logic [15:0] pl);
        return {12'b0, lbl, vc, pl};
    endfunction

    function automatic logic [15:0] hd(input logic [3:0] x, input logic [3:0] y, input logic [7:0] hp);
        return {x, y, hp};
    endfunction

    function automatic logic [31:0] obs_flit();
        return {12'b0, bus.data_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic hdr(input logic [3:0] x, input logic [3:0] y, input logic [7:0] hp, input logic [4:0] sz);
        bus.x_dest_i    = x;
        bus.y_dest_i    = y;
        bus.head_pl_i   = hp;
        bus.pkt_size_i  = sz;
        bus.pkt_valid_i = 1'b1;
    endtask

    initial begin
`ifdef NI_TX_VC_ROUND_ROBIN_EN
        rr_exp = '{2'd1, 2'd2, 2'd1};
`else
        rr_exp = '{2'd1, 2'd1, 2'd1};
`endif
        bus.pkt_valid_i      = 1'b0;
        bus.x_dest_i         = '0;
        bus.y_dest_i         = '0;
        bus.head_pl_i        = '0;
        bus.pkt_size_i       = '0;
        bus.body_valid_i     = 1'b0;
        bus.body_data_i      = '0;
        bus.on_off_i         = '0;
        bus.vc_allocatable_i = '0;

        // reset values, before any clock edge
        #3;
        chk("rst_valid", 32'(bus.valid_flit_o), 32'd0);
        chk("rst_data", obs_flit(), 32'd0);
        chk("rst_pkt_ready", 32'(bus.pkt_ready_o), 32'd0);
        chk("rst_body_ready", 32'(bus.body_ready_o), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // single-flit packet on VC0
        bus.on_off_i = 4'b1111;
        bus.vc_allocatable_i = 4'b0001;
        hdr(4'd2, 4'd2, 8'hA5, 5'd1);
        #1;
        chk("t1_pkt_ready", 32'(bus.pkt_ready_o), 32'd1);
        tick();
        bus.pkt_valid_i = 1'b0;
        chk("t1_no_flit_at_accept", 32'(bus.valid_flit_o), 32'd0);
        #1;
        chk("t1_busy", 32'(bus.pkt_ready_o), 32'd0);
        tick();
        chk("t1_valid", 32'(bus.valid_flit_o), 32'd1);
        chk("t1_flit", obs_flit(), mk(HEADTAIL, 2'd0, hd(4'd2, 4'd2, 8'hA5)));
        tick();
        chk("t1_valid_once", 32'(bus.valid_flit_o), 32'd0);
        chk("t1_idle_ready", 32'(bus.pkt_ready_o), 32'd1);

        // four-flit packet on VC2; allocatable change during SEND ignored
        bus.vc_allocatable_i = 4'b0100;
        bus.body_valid_i = 1'b1;
        hdr(4'd3, 4'd1, 8'h3C, 5'd4);
        tick();
        bus.pkt_valid_i = 1'b0;
        bus.vc_allocatable_i = 4'b0001;
        #1;
        chk("t2_body_ready_head", 32'(bus.body_ready_o), 32'd0);
        tick();
        chk("t2_head", obs_flit(), mk(HEAD, 2'd2, hd(4'd3, 4'd1, 8'h3C)));
        bus.body_data_i = 16'hB001;
        #1;
        chk("t2_body_ready", 32'(bus.body_ready_o), 32'd1);
        tick();
        chk("t2_body1", obs_flit(), mk(BODY, 2'd2, 16'hB001));
        bus.body_data_i = 16'hB002;
        tick();
        chk("t2_body2", obs_flit(), mk(BODY, 2'd2, 16'hB002));
        bus.body_data_i = 16'hB003;
        tick();
        chk("t2_tail", obs_flit(), mk(TAIL, 2'd2, 16'hB003));
        chk("t2_tail_valid", 32'(bus.valid_flit_o), 32'd1);
        chk("t2_ready_fifth", 32'(bus.pkt_ready_o), 32'd1);

        // backpressure on VC0 for 3 cycles after HEAD
        hdr(4'd1, 4'd0, 8'h11, 5'd3);
        bus.body_data_i = 16'hC001;
        tick();
        bus.pkt_valid_i = 1'b0;
        tick();
        chk("t3_head", obs_flit(), mk(HEAD, 2'd0, hd(4'd1, 4'd0, 8'h11)));
        bus.on_off_i = 4'b1110;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t3_stall_body_ready", 32'(bus.body_ready_o), 32'd0);
            tick();
            chk("t3_stall_valid", 32'(bus.valid_flit_o), 32'd0);
        end
        chk("t3_data_held", obs_flit(), mk(HEAD, 2'd0, hd(4'd1, 4'd0, 8'h11)));
        bus.on_off_i = 4'b1111;
        tick();
        chk("t3_body", obs_flit(), mk(BODY, 2'd0, 16'hC001));
        chk("t3_body_valid", 32'(bus.valid_flit_o), 32'd1);
        bus.body_data_i = 16'hC002;
        tick();
        chk("t3_tail", obs_flit(), mk(TAIL, 2'd0, 16'hC002));
        tick();
        chk("t3_after_valid", 32'(bus.valid_flit_o), 32'd0);

        // body starvation for 2 cycles mid-packet
        hdr(4'd4, 4'd5, 8'h44, 5'd4);
        tick();
        bus.pkt_valid_i = 1'b0;
        tick();
        chk("t4_head", obs_flit(), mk(HEAD, 2'd0, hd(4'd4, 4'd5, 8'h44)));
        bus.body_data_i = 16'hD001;
        tick();
        chk("t4_body1", obs_flit(), mk(BODY, 2'd0, 16'hD001));
        bus.body_valid_i = 1'b0;
        bus.body_data_i = 16'hDEAD;
        tick();
        chk("t4_starve1", 32'(bus.valid_flit_o), 32'd0);
        chk("t4_starve_body_ready", 32'(bus.body_ready_o), 32'd1);
        tick();
        chk("t4_starve2", 32'(bus.valid_flit_o), 32'd0);
        bus.body_valid_i = 1'b1;
        bus.body_data_i = 16'hD002;
        tick();
        chk("t4_body2", obs_flit(), mk(BODY, 2'd0, 16'hD002));
        bus.body_data_i = 16'hD003;
        tick();
        chk("t4_tail", obs_flit(), mk(TAIL, 2'd0, 16'hD003));

        // VC selection with VC1 and VC2 eligible
        bus.vc_allocatable_i = 4'b0110;
        for (int p = 0; p < 3; p++) begin
            hdr(4'(p), 4'd3, 8'(p), 5'd1);
            tick();
            bus.pkt_valid_i = 1'b0;
            tick();
            chk("t5_vc_pick", obs_flit(), mk(HEADTAIL, rr_exp[p], hd(4'(p), 4'd3, 8'(p))));
        end

        // size 0 behaves as a single flit
        bus.vc_allocatable_i = 4'b0001;
        hdr(4'd7, 4'd6, 8'h70, 5'd0);
        tick();
        bus.pkt_valid_i = 1'b0;
        tick();
        chk("t6_size0", obs_flit(), mk(HEADTAIL, 2'd0, hd(4'd7, 4'd6, 8'h70)));
        tick();
        chk("t6_size0_once", 32'(bus.valid_flit_o), 32'd0);

        // size above MAX_PKT_SIZE clamps to 16 flits
        hdr(4'd8, 4'd9, 8'h80, 5'd20);
        tick();
        bus.pkt_valid_i = 1'b0;
        for (int k = 0; k < 16; k++) begin
            bus.body_data_i = 16'(k) + 16'h0F00;
            tick();
            if (k == 0)
                chk("t7_clamp_head", obs_flit(), mk(HEAD, 2'd0, hd(4'd8, 4'd9, 8'h80)));
            else if (k == 15)
                chk("t7_clamp_tail", obs_flit(), mk(TAIL, 2'd0, 16'h0F0F));
            else
                chk("t7_clamp_body", obs_flit(), mk(BODY, 2'd0, 16'(k) + 16'h0F00));
        end
        tick();
        chk("t7_clamp_end", 32'(bus.valid_flit_o), 32'd0);

        // asynchronous reset after the 2nd flit of a 4-flit packet
        hdr(4'd5, 4'd5, 8'h55, 5'd4);
        tick();
        bus.pkt_valid_i = 1'b0;
        tick();
        bus.body_data_i = 16'hE001;
        tick();
        chk("t8_second_flit", obs_flit(), mk(BODY, 2'd0, 16'hE001));
        rst = 1'b1;
        #1;
        chk("t8_rst_valid", 32'(bus.valid_flit_o), 32'd0);
        chk("t8_rst_data", obs_flit(), 32'd0);
        chk("t8_rst_idle", 32'(bus.pkt_ready_o), 32'd1);
        chk("t8_rst_body_ready", 32'(bus.body_ready_o), 32'd0);
        tick();
        rst = 1'b0;
        hdr(4'd6, 4'd2, 8'h62, 5'd2);
        tick();
        bus.pkt_valid_i = 1'b0;
        tick();
        chk("t8_post_head", obs_flit(), mk(HEAD, 2'd0, hd(4'd6, 4'd2, 8'h62)));
        bus.body_data_i = 16'hE00F;
        tick();
        chk("t8_post_tail", obs_flit(), mk(TAIL, 2'd0, 16'hE00F));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
